// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run-control / shared-port arbiter:
// default stall constants, pause/resume command record and request class.
package core_ctrl_pkg;

    localparam int WR_STALL_DEF    = 6;
    localparam int RD_STALL_DEF    = 3;
    localparam int PAUSE_STALL_DEF = 6;

    // Command target field is sized for the largest supported build
    localparam int CMD_TGT_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 run;
        logic [CMD_TGT_W-1:0] target;
    } pr_cmd_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } req_class_e;

endpackage

// File: rtl/core_ctrl_arbiter_rr.sv
// Round-robin picker: first requester at or after ptr (modulo N),
// returned as a one-hot grant plus the winner index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner,
    output logic          valid
);

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!valid && req[wrap(int'(ptr) + off)]) begin
                valid                          = 1'b1;
                grant[wrap(int'(ptr) + off)]   = 1'b1;
                winner                         = IW'(wrap(int'(ptr) + off));
            end
        end
    end

endmodule

// File: rtl/core_ctrl_arbiter.sv
// Run/pause control and round-robin shared-port arbiter for NCORES cores.
// Optional per-core stall-cycle counters are enabled with ARB_PERF_CNT_EN.
module core_ctrl_arbiter
    import core_ctrl_pkg::*;
#(
    parameter int NCORES      = 2,
    parameter int IDX_W       = $clog2(NCORES),
    parameter int STALL_W     = 3,
    parameter int WR_STALL    = WR_STALL_DEF,
    parameter int RD_STALL    = RD_STALL_DEF,
    parameter int PAUSE_STALL = PAUSE_STALL_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCORES-1:0]         halt_i,
    input  logic [NCORES-1:0]         wen_i,
    input  logic [NCORES-1:0]         rd_i,
    input  logic [NCORES-1:0]         pr_valid_i,
    input  logic [NCORES-1:0]         pr_run_i,
    input  logic [NCORES*IDX_W-1:0]   pr_target_i,
    output logic [NCORES-1:0]         run_o,
    output logic [NCORES-1:0]         grant_o,
    output logic [NCORES*STALL_W-1:0] stall_o,
    output logic                      halt_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NCORES*32-1:0]      perf_o
`endif
);

    localparam logic [STALL_W-1:0] WR_S    = STALL_W'(WR_STALL);
    localparam logic [STALL_W-1:0] RD_S    = STALL_W'(RD_STALL);
    localparam logic [STALL_W-1:0] PAUSE_S = STALL_W'(PAUSE_STALL);

    logic [NCORES-1:0] run_q;
    logic [IDX_W-1:0]  rr_q;
    logic              halt_q;

    pr_cmd_t           cmd [NCORES];
    logic [NCORES-1:0] cmd_hit;
    logic [NCORES-1:0] cmd_run;
    logic [NCORES-1:0] eff_run;
    req_class_e        cls [NCORES];
    logic [NCORES-1:0] req_vec;
    logic [NCORES-1:0] wr_vec;
    logic [NCORES-1:0] compete;
    logic [IDX_W-1:0]  winner;
    logic              grant_vld;

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            cmd[i].valid  = pr_valid_i[i];
            cmd[i].run    = pr_run_i[i];
            cmd[i].target = CMD_TGT_W'(pr_target_i[i*IDX_W +: IDX_W]);
        end
    end

    // Scan issuers high-to-low so the lowest index is written last and wins;
    // out-of-range targets never match any core.
    always_comb begin
        cmd_hit = '0;
        cmd_run = '0;
        for (int k = 0; k < NCORES; k++) begin
            for (int i = NCORES - 1; i >= 0; i--) begin
                if (cmd[i].valid && int'(cmd[i].target) == k) begin
                    cmd_hit[k] = 1'b1;
                    cmd_run[k] = cmd[i].run;
                end
            end
        end
    end

    assign eff_run = run_q | (cmd_hit & cmd_run);

    always_comb begin
        for (int k = 0; k < NCORES; k++) begin
            cls[k] = REQ_NONE;
            if (eff_run[k] && wen_i[k])
                cls[k] = REQ_WRITE;
            else if (eff_run[k] && rd_i[k])
                cls[k] = REQ_READ;
            req_vec[k] = (cls[k] != REQ_NONE);
            wr_vec[k]  = (cls[k] == REQ_WRITE);
        end
    end

    // Writers take priority: readers only compete when nobody writes
    assign compete = (|wr_vec) ? wr_vec : req_vec;

    rr_arbiter #(
        .N  (NCORES),
        .IW (IDX_W)
    ) u_rr (
        .req    (compete),
        .ptr    (rr_q),
        .grant  (grant_o),
        .winner (winner),
        .valid  (grant_vld)
    );

    always_comb begin
        stall_o = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (!eff_run[k])
                stall_o[k*STALL_W +: STALL_W] = PAUSE_S;
            else if (grant_o[k])
                stall_o[k*STALL_W +: STALL_W] = '0;
            else if (cls[k] == REQ_WRITE)
                stall_o[k*STALL_W +: STALL_W] = WR_S;
            else if (cls[k] == REQ_READ)
                stall_o[k*STALL_W +: STALL_W] = RD_S;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= NCORES'(1);
            rr_q   <= '0;
            halt_q <= 1'b0;
        end else begin
            run_q <= (run_q & ~cmd_hit) | (cmd_hit & cmd_run);
            if (grant_vld)
                rr_q <= (int'(winner) == NCORES - 1) ? '0 : winner + 1'b1;
            if (&halt_i)
                halt_q <= 1'b1;
        end
    end

    assign run_o  = run_q;
    assign halt_o = halt_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_q [NCORES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCORES; k++)
                perf_q[k] <= '0;
        end else if (!halt_q) begin
            for (int k = 0; k < NCORES; k++) begin
                if (stall_o[k*STALL_W +: STALL_W] != '0 && perf_q[k] != '1)
                    perf_q[k] <= perf_q[k] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCORES; k++)
            perf_o[k*32 +: 32] = perf_q[k];
    end
`endif

endmodule

// File: tb/tb_core_ctrl_arbiter.sv
// Directed bench for core_ctrl_arbiter with four cores; perf counter
// checks are included when ARB_PERF_CNT_EN is defined.
module tb_core_ctrl_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int SW = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    halt_i;
    logic [N-1:0]    wen_i;
    logic [N-1:0]    rd_i;
    logic [N-1:0]    pr_valid_i;
    logic [N-1:0]    pr_run_i;
    logic [N*IW-1:0] pr_target_i;
    logic [N-1:0]    run_o;
    logic [N-1:0]    grant_o;
    logic [N*SW-1:0] stall_o;
    logic            halt_o;
`ifdef ARB_PERF_CNT_EN
    logic [N*32-1:0] perf_o;
`endif

    int total = 0;
    int bad   = 0;

    core_ctrl_arbiter #(
        .NCORES (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt_i      (halt_i),
        .wen_i       (wen_i),
        .rd_i        (rd_i),
        .pr_valid_i  (pr_valid_i),
        .pr_run_i    (pr_run_i),
        .pr_target_i (pr_target_i),
        .run_o       (run_o),
        .grant_o     (grant_o),
        .stall_o     (stall_o),
        .halt_o      (halt_o)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_o      (perf_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int s0, input int s1, input int s2, input int s3);
        logic [11:0] v;
        v = {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
        return {20'd0, v};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen_i       = '0;
        rd_i        = '0;
        pr_valid_i  = '0;
        pr_run_i    = '0;
        pr_target_i = '0;
    endtask

    initial begin
        rst_n  = 1'b0;
        halt_i = '0;
        idle_inputs();
        cyc();
        cyc();
        chk("reset_run", 32'(run_o), 32'h1);
        chk("reset_halt", 32'(halt_o), 32'h0);
        rst_n = 1'b1;
        cyc();

        // Idle after reset: only core 0 runs, others see pause stall
        chk("idle_run", 32'(run_o), 32'h1);
        chk("idle_stall", 32'(stall_o), pk(0, 6, 6, 6));
        chk("idle_grant", 32'(grant_o), 32'h0);
        chk("idle_halt", 32'(halt_o), 32'h0);

        // Core 0 resumes core 1: bypass in the command cycle
        pr_valid_i = 4'b0001; pr_run_i = 4'b0001; pr_target_i = 8'b00_00_00_01;
        #1;
        chk("bypass_stall", 32'(stall_o), pk(0, 0, 6, 6));
        chk("bypass_run_before", 32'(run_o), 32'h1);
        cyc();
        chk("resume_run", 32'(run_o), 32'h3);

        // Core 0 resumes core 2, core 1 resumes core 3
        pr_valid_i = 4'b0011; pr_run_i = 4'b0011; pr_target_i = 8'b00_00_11_10;
        #1;
        chk("resume23_stall", 32'(stall_o), pk(0, 0, 0, 0));
        cyc();
        chk("all_run", 32'(run_o), 32'hF);
        idle_inputs();

        // All cores write for four cycles: round-robin 0,1,2,3
        wen_i = 4'b1111;
        for (int i = 0; i < N; i++) begin
            #1;
            chk("allwr_grant", 32'(grant_o), 32'(1 << i));
            chk("allwr_stall", 32'(stall_o),
                pk(i == 0 ? 0 : 6, i == 1 ? 0 : 6, i == 2 ? 0 : 6, i == 3 ? 0 : 6));
            cyc();
        end
        wen_i = '0;

        // Pointer wrapped to 0: core 0 reads, core 2 writes -> core 2 wins
        rd_i = 4'b0001; wen_i = 4'b0100;
        #1;
        chk("wr_prio_grant", 32'(grant_o), 32'h4);
        chk("wr_prio_stall", 32'(stall_o), pk(3, 0, 0, 0));
        cyc();

        // Pointer now 3: readers 0 and 3 -> core 3 wins
        rd_i = 4'b1001; wen_i = 4'b0000;
        #1;
        chk("ptr3_grant", 32'(grant_o), 32'h8);
        chk("ptr3_stall", 32'(stall_o), pk(3, 0, 0, 0));
        cyc();
        idle_inputs();

        // Core 0 pauses core 1 while core 2 resumes it: core 0 wins
        pr_valid_i = 4'b0101; pr_run_i = 4'b0100; pr_target_i = 8'b00_01_00_01;
        #1;
        chk("conflict_stall", 32'(stall_o), pk(0, 0, 0, 0));
        cyc();
        idle_inputs();
        chk("conflict_run", 32'(run_o), 32'hD);
        #1;
        chk("paused_stall", 32'(stall_o), pk(0, 6, 0, 0));

        // Paused core 1 writes (masked), core 0 reads: core 0 granted
        wen_i = 4'b0010; rd_i = 4'b0001;
        #1;
        chk("masked_grant", 32'(grant_o), 32'h1);
        chk("masked_stall", 32'(stall_o), pk(0, 6, 0, 0));
        cyc();
        idle_inputs();

        // Core 3 pauses itself
        pr_valid_i = 4'b1000; pr_run_i = 4'b0000; pr_target_i = 8'b11_00_00_00;
        cyc();
        idle_inputs();
        chk("self_pause_run", 32'(run_o), 32'h5);

        // Partial halt does nothing, full halt sets sticky flag
        halt_i = 4'b0111;
        cyc();
        chk("partial_halt", 32'(halt_o), 32'h0);
        halt_i = 4'b1111;
        cyc();
        chk("full_halt", 32'(halt_o), 32'h1);
        halt_i = 4'b0000;
        cyc();
        chk("sticky_halt", 32'(halt_o), 32'h1);
        wen_i = 4'b0001;
        #1;
        chk("halted_grant", 32'(grant_o), 32'h1);
        cyc();
        idle_inputs();

        // Asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        chk("async_rst_run", 32'(run_o), 32'h1);
        chk("async_rst_halt", 32'(halt_o), 32'h0);
        rst_n = 1'b1;

        // Five stalled cycles for paused cores 1..3
        for (int i = 0; i < 5; i++) cyc();
`ifdef ARB_PERF_CNT_EN
        chk("perf1_5", perf_o[63:32], 32'd5);
        chk("perf0_0", perf_o[31:0], 32'd0);
`endif
        halt_i = 4'b1111;
        cyc();
        chk("halt_after_rst", 32'(halt_o), 32'h1);
`ifdef ARB_PERF_CNT_EN
        chk("perf1_6", perf_o[63:32], 32'd6);
`endif
        for (int i = 0; i < 3; i++) cyc();
`ifdef ARB_PERF_CNT_EN
        chk("perf1_frozen", perf_o[63:32], 32'd6);
        chk("perf3_frozen", perf_o[127:96], 32'd6);
`endif
        chk("final_run", 32'(run_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
